pbit_sample: RTL

Stochastic sampling stage of the p-bit, directly downstream of the tanh lookup. Each requested update adds a uniform random value in [-1, 1) to the tanh output and emits the sign as the p-bit state m (1 = +1, 0 = -1). Randomness comes from an internal free-running 32-bit Galois LFSR with a loadable seed. The stage is a two-stage pipeline, so the p-bit array can issue one update per cycle.

---
 rtl/pbit_sample.sv | 116 +++++++++++
 1 files changed

// File: rtl/pbit_sample.sv
// p-bit stochastic sampling stage: tanh value plus LFSR noise, sign taken as the p-bit state.
// Optional statistics counters (ones_cnt, samp_cnt, stats_clr) are built when PBIT_STATS_EN is defined.

package pbit_sample_pkg;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RND_W  = 31;
    localparam int unsigned SUM_W  = 33;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [DATA_W-1:0] tanh;
        logic [RND_W-1:0]  rnd;
    } stage1_t;
endpackage

module pbit_sample
    import pbit_sample_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2468,
    parameter logic [31:0] TAPS = 32'h8020_0003
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tanh_in,
    input  logic              update,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed,
`ifdef PBIT_STATS_EN
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  ones_cnt,
    output logic [CNT_W-1:0]  samp_cnt,
`endif
    output logic              m,
    output logic              m_valid
);

    // A zero seed would lock the LFSR, so it is replaced by 1 everywhere.
    localparam logic [DATA_W-1:0] SEED_INIT = (SEED == '0) ? DATA_W'(1) : SEED;

    logic [DATA_W-1:0] lfsr;
    logic [DATA_W-1:0] lfsr_step_c;
    logic [DATA_W-1:0] seed_fix_c;
    stage1_t           s1_q;
    logic              v1;
    logic [SUM_W-1:0]  sum_c;

    // Next LFSR state and sanitised seed.
    always_comb begin
        lfsr_step_c = lfsr >> 1;
        if (lfsr[0]) begin
            lfsr_step_c = (lfsr >> 1) ^ TAPS;
        end
        seed_fix_c = (seed == '0) ? DATA_W'(1) : seed;
    end

    // Free-running noise source; a seed load replaces the step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= SEED_INIT;
        end else if (seed_load) begin
            lfsr <= seed_fix_c;
        end else begin
            lfsr <= lfsr_step_c;
        end
    end

    // Stage 1: capture tanh and the pre-edge LFSR value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            v1   <= 1'b0;
        end else begin
            v1 <= update;
            if (update) begin
                s1_q.tanh <= tanh_in;
                s1_q.rnd  <= lfsr[RND_W-1:0];
            end
        end
    end

    // Both operands fit in 31/32 signed bits, so a 33-bit sum never overflows.
    always_comb begin
        sum_c = {s1_q.tanh[DATA_W-1], s1_q.tanh}
              + {{(SUM_W-RND_W){s1_q.rnd[RND_W-1]}}, s1_q.rnd};
    end

    // Stage 2: sign decision; m holds between updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m       <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= v1;
            if (v1) begin
                m <= ~sum_c[SUM_W-1];
            end
        end
    end

`ifdef PBIT_STATS_EN
    // Sample statistics; both counters freeze once samp_cnt saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_cnt <= '0;
            samp_cnt <= '0;
        end else if (stats_clr) begin
            ones_cnt <= '0;
            samp_cnt <= '0;
        end else if (m_valid && (samp_cnt != {CNT_W{1'b1}})) begin
            samp_cnt <= samp_cnt + CNT_W'(1);
            ones_cnt <= ones_cnt + CNT_W'(m);
        end
    end
`endif

endmodule
